// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, one-hot T-states,
// control-word bit positions and the combinational T-state/opcode decode.
package sap_pkg;

    localparam int OPCODE_W     = 4;
    localparam int NUM_T_STATES = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [NUM_T_STATES-1:0] T1 = 6'b000001;
    localparam logic [NUM_T_STATES-1:0] T2 = 6'b000010;
    localparam logic [NUM_T_STATES-1:0] T3 = 6'b000100;
    localparam logic [NUM_T_STATES-1:0] T4 = 6'b001000;
    localparam logic [NUM_T_STATES-1:0] T5 = 6'b010000;
    localparam logic [NUM_T_STATES-1:0] T6 = 6'b100000;

    // Bit positions inside the packed control word, shared with the datapath top.
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_RAM_OUT  = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_A_LOAD   = 6;
    localparam int CW_A_OUT    = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_ALU_SUB  = 9;
    localparam int CW_ALU_OUT  = 10;
    localparam int CW_OUT_LOAD = 11;
    localparam int CW_WIDTH    = 12;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    // Raw enables for one T-state and opcode; run/halt/clr gating is applied by the caller.
    function automatic ctrl_word_t decode_cw(input logic [NUM_T_STATES-1:0] t,
                                             input logic [OPCODE_W-1:0]     op);
        ctrl_word_t cw;
        cw = {CW_WIDTH{1'b0}};
        case (t)
            T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T2: begin
                cw[CW_PC_INC] = 1'b1;
            end
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            T6: begin
                case (op)
                    OP_ADD: begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                        cw[CW_ALU_SUB] = 1'b1;
                    end
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            default: cw = {CW_WIDTH{1'b0}};
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring: clears to T1, rotates one position per enabled cycle.
module ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [NUM_T-1:0] t_state
);

    localparam logic [NUM_T-1:0] T_FIRST = {{(NUM_T-1){1'b0}}, 1'b1};

    logic [NUM_T-1:0] ring_r;

    // Ring register; a corrupted (non one-hot) value falls back to T1 rather than locking up.
    always_ff @(posedge clk) begin
        if (clr) begin
            ring_r <= T_FIRST;
        end else if (!$onehot(ring_r)) begin
            ring_r <= T_FIRST;
        end else if (en) begin
            ring_r <= {ring_r[NUM_T-2:0], ring_r[NUM_T-1]};
        end else begin
            ring_r <= ring_r;
        end
    end

    assign t_state = ring_r;

endmodule

// File: rtl/sap_control_sequencer_checker.sv
// Protocol properties of the sequencer outputs: one-hot ring, single bus driver,
// and a frozen, silent, sticky halt.
module sap_control_sequencer_checker
    import sap_pkg::*;
(
    input logic       clk,
    input logic       clr,
    input logic       pc_inc,
    input logic       pc_out,
    input logic       mar_load,
    input logic       ram_out,
    input logic       ir_load,
    input logic       ir_out,
    input logic       a_load,
    input logic       a_out,
    input logic       b_load,
    input logic       alu_sub,
    input logic       alu_out,
    input logic       out_load,
    input logic       halt,
    input logic [5:0] t_state
);

    logic [11:0] all_en_s;
    assign all_en_s = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                       a_load, a_out, b_load, alu_sub, alu_out, out_load};

    a_ring_onehot: assert property (@(posedge clk) disable iff (clr) $onehot(t_state))
        else $error("t_state is not one-hot: %b", t_state);

    a_one_bus_driver: assert property (@(posedge clk) disable iff (clr)
        $countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1)
        else $error("more than one bus driver active");

    a_halt_frozen: assert property (@(posedge clk) disable iff (clr)
        halt |-> (t_state == T4) && (all_en_s == 12'h000))
        else $error("halted but ring moved or enables active");

    a_halt_sticky: assert property (@(posedge clk) disable iff (clr) halt |=> halt)
        else $error("halt dropped without clr");

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T-state ring, sticky halt flag and the Moore decode of
// ring state / opcode / run / halt into the bus and load enables.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int NUM_T        = 6
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    pc_inc,
    output logic                    pc_out,
    output logic                    mar_load,
    output logic                    ram_out,
    output logic                    ir_load,
    output logic                    ir_out,
    output logic                    a_load,
    output logic                    a_out,
    output logic                    b_load,
    output logic                    alu_sub,
    output logic                    alu_out,
    output logic                    out_load,
    output logic                    halt,
    output logic [NUM_T-1:0]        t_state
);

    logic [NUM_T-1:0] t_state_s;
    logic             halt_r;
    logic             halt_set_s;
    logic             ring_en_s;
    ctrl_word_t       cw_s;

    ring_counter #(
        .NUM_T (NUM_T)
    ) u_ring (
        .clk     (clk),
        .clr     (clr),
        .en      (ring_en_s),
        .t_state (t_state_s)
    );

    // HLT is captured on the T4 edge; the ring must not step past T4 on that same edge.
    always_comb begin
        halt_set_s = 1'b0;
        if (run && !halt_r && (t_state_s == T4) && (opcode == OP_HLT)) begin
            halt_set_s = 1'b1;
        end else begin
            halt_set_s = 1'b0;
        end
        ring_en_s = run & ~halt_r & ~halt_set_s;
    end

    // Sticky halt flag; only clr releases it, and clr wins over a same-edge capture.
    always_ff @(posedge clk) begin
        if (clr) begin
            halt_r <= 1'b0;
        end else if (halt_set_s) begin
            halt_r <= 1'b1;
        end else begin
            halt_r <= halt_r;
        end
    end

    // Enables are silenced during reset, pause and halt so a paused state re-runs cleanly.
    always_comb begin
        cw_s = {CW_WIDTH{1'b0}};
        if (clr || !run || halt_r) begin
            cw_s = {CW_WIDTH{1'b0}};
        end else begin
            cw_s = decode_cw(t_state_s, opcode);
        end
    end

    assign pc_inc   = cw_s[CW_PC_INC];
    assign pc_out   = cw_s[CW_PC_OUT];
    assign mar_load = cw_s[CW_MAR_LOAD];
    assign ram_out  = cw_s[CW_RAM_OUT];
    assign ir_load  = cw_s[CW_IR_LOAD];
    assign ir_out   = cw_s[CW_IR_OUT];
    assign a_load   = cw_s[CW_A_LOAD];
    assign a_out    = cw_s[CW_A_OUT];
    assign b_load   = cw_s[CW_B_LOAD];
    assign alu_sub  = cw_s[CW_ALU_SUB];
    assign alu_out  = cw_s[CW_ALU_OUT];
    assign out_load = cw_s[CW_OUT_LOAD];
    assign halt     = halt_r & ~clr;
    assign t_state  = t_state_s;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed, table-driven bench for sap_control_sequencer; expected enables are
// hand-derived from the instruction timing table.
module tb_sap_control_sequencer;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    // Bench packing: {pc_inc,pc_out,mar_load,ram_out,ir_load,ir_out,a_load,a_out,b_load,alu_sub,alu_out,out_load}
    localparam logic [11:0] E_NONE = 12'h000;
    localparam logic [11:0] E_PCI  = 12'h800;
    localparam logic [11:0] E_PCO  = 12'h400;
    localparam logic [11:0] E_MAR  = 12'h200;
    localparam logic [11:0] E_RAM  = 12'h100;
    localparam logic [11:0] E_IRL  = 12'h080;
    localparam logic [11:0] E_IRO  = 12'h040;
    localparam logic [11:0] E_AL   = 12'h020;
    localparam logic [11:0] E_AO   = 12'h010;
    localparam logic [11:0] E_BL   = 12'h008;
    localparam logic [11:0] E_SUB  = 12'h004;
    localparam logic [11:0] E_ALU  = 12'h002;
    localparam logic [11:0] E_OUTL = 12'h001;

    typedef struct {
        logic       clr;
        logic       run;
        logic [3:0] op;
        logic [5:0] t;
        logic [11:0] en;
        logic       halt;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic [3:0] opcode;
    logic pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic a_load, a_out, b_load, alu_sub, alu_out, out_load, halt;
    logic [5:0] t_state;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .opcode(opcode),
        .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
        .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
        .b_load(b_load), .alu_sub(alu_sub), .alu_out(alu_out), .out_load(out_load),
        .halt(halt), .t_state(t_state)
    );

    sap_control_sequencer_checker chk (
        .clk(clk), .clr(clr),
        .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
        .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
        .b_load(b_load), .alu_sub(alu_sub), .alu_out(alu_out), .out_load(out_load),
        .halt(halt), .t_state(t_state)
    );

    task automatic add(input logic c, input logic r, input logic [3:0] o,
                       input logic [5:0] t, input logic [11:0] e, input logic h);
        vec_t v;
        v.clr = c; v.run = r; v.op = o; v.t = t; v.en = e; v.halt = h;
        vecs.push_back(v);
    endtask

    // Fetch rows; the opcode driven here is deliberately junk since T1-T3 must ignore it.
    task automatic add_fetch(input logic [3:0] junk);
        add(1'b0, 1'b1, junk, S1, E_PCO | E_MAR, 1'b0);
        add(1'b0, 1'b1, junk, S2, E_PCI, 1'b0);
        add(1'b0, 1'b1, junk, S3, E_RAM | E_IRL, 1'b0);
    endtask

    task automatic add_exec(input logic [3:0] op, input logic [11:0] e4,
                            input logic [11:0] e5, input logic [11:0] e6);
        add(1'b0, 1'b1, op, S4, e4, 1'b0);
        add(1'b0, 1'b1, op, S5, e5, 1'b0);
        add(1'b0, 1'b1, op, S6, e6, 1'b0);
    endtask

    // Drive one cycle's inputs at the falling edge, compare mid-cycle, then let the rising edge act.
    task automatic apply_check(input vec_t v, input string tag);
        logic [11:0] got;
        @(negedge clk);
        clr = v.clr; run = v.run; opcode = v.op;
        #1;
        got = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_sub, alu_out, out_load};
        checks++;
        if (t_state !== v.t) begin
            errors++;
            $display("FAIL %s t_state: got %b expected %b", tag, t_state, v.t);
        end
        checks++;
        if (got !== v.en) begin
            errors++;
            $display("FAIL %s enables: got %h expected %h", tag, got, v.en);
        end
        checks++;
        if (halt !== v.halt) begin
            errors++;
            $display("FAIL %s halt: got %b expected %b", tag, halt, v.halt);
        end
        checks++;
        if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
            errors++;
            $display("FAIL %s bus_drivers: got %b expected at most one", tag,
                     {pc_out, ram_out, ir_out, a_out, alu_out});
        end
    endtask

    initial begin
        vec_t v;
        clr = 1'b1; run = 1'b0; opcode = 4'h0;
        repeat (2) @(posedge clk);

        // Reset state, held with run high as well
        add(1'b1, 1'b0, 4'h0, S1, E_NONE, 1'b0);
        add(1'b1, 1'b1, 4'hF, S1, E_NONE, 1'b0);
        // LDA
        add_fetch(4'hF);
        add_exec(4'h0, E_IRO | E_MAR, E_RAM | E_AL, E_NONE);
        // ADD, SUB
        add_fetch(4'h2);
        add_exec(4'h1, E_IRO | E_MAR, E_RAM | E_BL, E_ALU | E_AL);
        add_fetch(4'h1);
        add_exec(4'h2, E_IRO | E_MAR, E_RAM | E_BL, E_ALU | E_AL | E_SUB);
        // OUT then undefined 4'h7
        add_fetch(4'h0);
        add_exec(4'hE, E_AO | E_OUTL, E_NONE, E_NONE);
        add_fetch(4'hE);
        add_exec(4'h7, E_NONE, E_NONE, E_NONE);
        // ADD with run low for 3 cycles in T5: 9-cycle instruction
        add_fetch(4'h1);
        add(1'b0, 1'b1, 4'h1, S4, E_IRO | E_MAR, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'h1, S5, E_NONE, 1'b0);
        add(1'b0, 1'b1, 4'h1, S5, E_RAM | E_BL, 1'b0);
        add(1'b0, 1'b1, 4'h1, S6, E_ALU | E_AL, 1'b0);
        // clr during T3 with run high
        add(1'b0, 1'b1, 4'h0, S1, E_PCO | E_MAR, 1'b0);
        add(1'b0, 1'b1, 4'h0, S2, E_PCI, 1'b0);
        add(1'b1, 1'b1, 4'h0, S3, E_NONE, 1'b0);
        add(1'b1, 1'b1, 4'h0, S1, E_NONE, 1'b0);
        add(1'b0, 1'b1, 4'h0, S1, E_PCO | E_MAR, 1'b0);
        add(1'b0, 1'b1, 4'h0, S2, E_PCI, 1'b0);
        add(1'b0, 1'b1, 4'h0, S3, E_RAM | E_IRL, 1'b0);
        // HLT: nothing in T4, then halted
        add(1'b0, 1'b1, 4'hF, S4, E_NONE, 1'b0);

        foreach (vecs[i]) apply_check(vecs[i], $sformatf("vec%0d", i));

        // Halted for 20 cycles with arbitrary run/opcode: frozen at T4, silent
        for (int i = 0; i < 20; i++) begin
            v.clr = 1'b0; v.run = 1'($urandom_range(1, 0)); v.op = 4'($urandom_range(15, 0));
            v.t = S4; v.en = E_NONE; v.halt = 1'b1;
            apply_check(v, $sformatf("halted%0d", i));
        end

        // clr pulse releases halt; fetch restarts from T1
        v.clr = 1'b1; v.run = 1'b1; v.op = 4'hF; v.t = S4; v.en = E_NONE; v.halt = 1'b0;
        apply_check(v, "halt_clr_same");
        v.clr = 1'b0; v.run = 1'b1; v.op = 4'h0; v.t = S1; v.en = E_PCO | E_MAR; v.halt = 1'b0;
        apply_check(v, "after_halt_t1");
        v.t = S2; v.en = E_PCI;
        apply_check(v, "after_halt_t2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Control sequencer for the SAP-1 datapath: a six-state one-hot ring counter (T1–T6) plus opcode decode that drives the load/output enables of the PC, MAR, RAM, IR, A, B, ALU and output registers each clock. It sits between the IR opcode field and every enable-gated register on the shared 8-bit bus. It fetches every instruction in T1–T3 and executes LDA, ADD, SUB, OUT, HLT in T4–T6. It honours a run/pause input and latches a halt that only reset clears.

## Interface
- OPCODE_WIDTH, 4, width of the opcode field taken from the IR upper bits.
- NUM_T, 6, ring length; fixed at 6 for this instruction set, not to be overridden.
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- run  in  1  1 = advance the ring each cycle; 0 = hold the current T-state and force all enables to 0.
- opcode  in  OPCODE_WIDTH  IR[7:4]; sampled combinationally, valid from T4 onward.
- pc_inc  out  1  program counter increment enable.
- pc_out  out  1  PC drives the bus.
- mar_load  out  1  MAR load enable.
- ram_out  out  1  RAM drives the bus.
- ir_load  out  1  IR load enable.
- ir_out  out  1  IR[3:0] drives the bus.
- a_load  out  1  accumulator load enable.
- a_out  out  1  accumulator drives the bus.
- b_load  out  1  B register load enable.
- alu_sub  out  1  ALU subtract select (0 = add).
- alu_out  out  1  ALU drives the bus.
- out_load  out  1  output register load enable.
- halt  out  1  processor halted (clock-stop request).
- t_state  out  NUM_T  one-hot current T-state, for debug.

## Operation
- Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. Any other code is a NOP: T4–T6 assert nothing.
- Fetch, identical for all instructions:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- LDA: T4 ir_out, mar_load. T5 ram_out, a_load. T6 none.
- ADD: T4 ir_out, mar_load. T5 ram_out, b_load. T6 alu_out, a_load.
- SUB: same as ADD, with alu_sub also asserted in T6.
- OUT: T4 a_out, out_load. T5 none. T6 none.
- HLT:
  - T4 asserts nothing.
  - The halt flag sets on the T4 edge.
  - The ring freezes at T4.
  - All enables are 0 while halted. Only clr clears halt.
- Bus rule: at most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle.
- Enables are a Moore decode of the ring state, the opcode, run and halt. The controlled registers sample them on the next rising edge.
- Ring advances T1→T2→…→T6→T1, one step per cycle while run=1 and halt=0.
- The ring always runs all six states. There is no early return to T1.

## Timing
- Reset:
  - A rising edge with clr=1 sets the ring to T1 and clears halt.
  - While clr=1, all enable outputs and halt are forced to 0; t_state shows the registered value.
  - On the first cycle after clr falls, T1 enables are driven.
- clr has priority over run and over a halt capture on the same edge.
- clr asserted mid-instruction (any T-state): the instruction is abandoned and fetch restarts at T1. There are no partial side effects beyond enables already sampled.
- Instruction latency is 6 cycles with run held high. A pause extends it by the number of run=0 cycles.
- run falling during a T-state:
  - The enables of that state are suppressed for that cycle.
  - The state is re-executed in full when run returns to 1.
- halt rises on the cycle after the T4 edge of HLT and stays high. t_state holds T4.
- opcode is ignored in T1–T3. In T4–T6 it must be stable; it is not registered internally.

## Structure
- Shared package sap_pkg:
  - opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - one-hot T-state constants T1..T6;
  - control-word bit indices, so the datapath top can also consume a packed control word.
- Sub-module ring_counter (NUM_T one-hot, inputs clk, clr, en):
  - synchronous clear to T1;
  - rotates when en=1, where en = run & ~halt.
- The top instantiates ring_counter, holds the halt flag, and contains the combinational decode.

## Test plan
- Reset, then run=1, opcode=4'h0 (LDA) from T4:
  - t_state steps 000001→000010→…→100000→000001;
  - enables are exactly T1{pc_out,mar_load}, T2{pc_inc}, T3{ram_out,ir_load}, T4{ir_out,mar_load}, T5{ram_out,a_load}, T6{}.
- ADD then SUB (opcode 4'h1, then 4'h2):
  - T5 b_load; T6 alu_out, a_load;
  - alu_sub=0 for ADD and 1 only in SUB's T6;
  - check the one-bus-driver invariant every cycle.
- OUT (4'hE) followed by an undefined opcode 4'h7:
  - OUT gives T4 a_out, out_load;
  - 4'h7 gives zero enables in T4–T6 and the next fetch starts at T1.
- HLT (4'hF):
  - halt=1 from the cycle after T4; t_state frozen at T4; all enables 0 for 20 further cycles;
  - clr pulse returns to T1 with halt=0.
- run=0 held 3 cycles during T5 of ADD:
  - t_state stays T5 and enables are 0 for 3 cycles;
  - on run=1, T5 {ram_out, b_load} is asserted once;
  - total instruction length is 9 cycles.
- clr asserted during T3 with run=1:
  - next cycle t_state=T1, all enables 0 while clr=1;
  - T1 enables appear the cycle after clr falls.
